// File: rtl/overlay_fetch_if.sv
// overlay_fetch_if
// Read-channel bundle between the overlay fetcher and the SDRAM ch1 read port.
//   mem_req  : one-cycle read request pulse (fetcher -> memory)
//   mem_addr : word address, valid while mem_req is high (fetcher -> memory)
//   mem_ack  : one-cycle pulse marking mem_din valid (memory -> fetcher)
//   mem_din  : read data word (memory -> fetcher)
// The master modport is the fetcher side; the slave modport is the memory side.
interface overlay_fetch_if #(
  parameter int ADDR_W = 24,
  parameter int WORD_W = 32
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [WORD_W-1:0] mem_din;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_din
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_din
  );
endinterface

// File: rtl/overlay_fetch.sv
// overlay_fetch
// Streams packed overlay pixels from the SDRAM read channel into the pixel
// pipeline. Words are prefetched into a small FIFO, one read outstanding at a
// time, and unpacked little-endian (pixel 0 in the low bits) one pixel per
// consume. A vsync rising edge restarts the frame at BASE and discards any
// read that was already in flight.
// Ports:
//   clk         : pixel-domain clock
//   reset       : asynchronous, active-high reset
//   enable      : overlay present and usable
//   ce_pix      : pixel clock enable
//   vsync       : vertical sync, active high
//   de          : display enable; a pixel is consumed when ce_pix & de
//   mem         : read channel (overlay_fetch_if.master)
//   pix_out     : current overlay pixel
//   frame_start : one-cycle pulse on vsync rising edge
//   underrun    : sticky, set when a pixel is consumed with no data buffered
// WORD_W must be a multiple of PIX_W; FIFO_DEPTH must be a power of 2, >= 2.
module overlay_fetch #(
  parameter int                ADDR_W     = 24,
  parameter int                WORD_W     = 32,
  parameter int                PIX_W      = 16,
  parameter int                FIFO_DEPTH = 8,
  parameter logic [ADDR_W-1:0] BASE       = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             ce_pix,
  input  logic             vsync,
  input  logic             de,
  overlay_fetch_if.master  mem,
  output logic [PIX_W-1:0] pix_out,
  output logic             frame_start,
  output logic             underrun
);

  localparam int PPW   = WORD_W / PIX_W;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int IDX_W = (PPW > 1) ? $clog2(PPW) : 1;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PPW - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RUN     = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;
  localparam logic [1:0] S_DISCARD = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              req_q, req_d;
  logic [PIX_W-1:0]  pix_q, pix_d;
  logic              fs_q, fs_d;
  logic              ur_q, ur_d;
  logic              pend_q, pend_d;
  logic              vs_q;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [PTR_W-1:0]  rd_q, rd_d;
  logic [PTR_W-1:0]  wr_q, wr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] fifo_q [FIFO_DEPTH];

  logic              vs_edge;
  logic              push;
  logic              pop;
  logic              flush;
  logic [WORD_W-1:0] head_word;
  logic [PIX_W-1:0]  head_pix;

  assign vs_edge   = vsync & ~vs_q;
  assign head_word = fifo_q[rd_q];
  assign head_pix  = head_word[idx_q*PIX_W +: PIX_W];

  // pend_q remembers a read that was abandoned by dropping enable. If the
  // overlay is re-enabled before that ack shows up, we pass through DISCARD
  // so the stale word is never mistaken for the reply to a fresh request.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    req_d   = 1'b0;
    pix_d   = pix_q;
    fs_d    = 1'b0;
    ur_d    = ur_q;
    pend_d  = pend_q;
    idx_d   = idx_q;
    push    = 1'b0;
    pop     = 1'b0;
    flush   = 1'b0;

    if (mem.mem_ack) begin
      pend_d = 1'b0;
    end

    if (!enable) begin
      state_d = S_IDLE;
      pix_d   = '0;
      flush   = 1'b1;
      idx_d   = '0;
      if ((state_q == S_WAIT || state_q == S_DISCARD) && !mem.mem_ack) begin
        pend_d = 1'b1;
      end
      // The frame restart still registers while disabled so that the next
      // enable after a vsync begins at BASE.
      if (vs_edge) begin
        fs_d   = 1'b1;
        addr_d = BASE;
        ur_d   = 1'b0;
      end
    end else if (vs_edge) begin
      // Restart the frame; pix_out holds and any consume this cycle is moot
      // because the FIFO is being flushed.
      fs_d   = 1'b1;
      flush  = 1'b1;
      idx_d  = '0;
      addr_d = BASE;
      ur_d   = 1'b0;
      case (state_q)
        S_WAIT, S_DISCARD: state_d = mem.mem_ack ? S_RUN : S_DISCARD;
        S_IDLE:            state_d = (pend_q && !mem.mem_ack) ? S_DISCARD : S_RUN;
        default:           state_d = S_RUN;
      endcase
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = (pend_q && !mem.mem_ack) ? S_DISCARD : S_RUN;
        end
        S_RUN: begin
          // Occupancy alone gates the request; a same-cycle pop does not
          // open a slot until the next cycle.
          if (cnt_q != FULL_CNT) begin
            req_d   = 1'b1;
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem.mem_ack) begin
            push    = 1'b1;
            addr_d  = addr_q + 1'b1;
            state_d = S_RUN;
          end
        end
        default: begin
          if (mem.mem_ack) begin
            state_d = S_RUN;
          end
        end
      endcase

      if (ce_pix && de && state_q != S_IDLE) begin
        if (cnt_q == '0) begin
          pix_d = '0;
          ur_d  = 1'b1;
        end else begin
          pix_d = head_pix;
          if (idx_q == LAST_IDX) begin
            pop   = 1'b1;
            idx_d = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
    end
  end

  // FIFO pointer and occupancy bookkeeping; push and pop together leave the
  // occupancy unchanged.
  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) begin
        wr_d = wr_q + 1'b1;
      end
      if (pop) begin
        rd_d = rd_q + 1'b1;
      end
      if (push && !pop) begin
        cnt_d = cnt_q + 1'b1;
      end else if (pop && !push) begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= BASE;
      req_q   <= 1'b0;
      pix_q   <= '0;
      fs_q    <= 1'b0;
      ur_q    <= 1'b0;
      pend_q  <= 1'b0;
      vs_q    <= 1'b0;
      idx_q   <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      pix_q   <= pix_d;
      fs_q    <= fs_d;
      ur_q    <= ur_d;
      pend_q  <= pend_d;
      vs_q    <= vsync;
      idx_q   <= idx_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Word storage needs no reset; occupancy decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_q] <= mem.mem_din;
    end
  end

  assign mem.mem_req  = req_q;
  assign mem.mem_addr = addr_q;
  assign pix_out      = pix_q;
  assign frame_start  = fs_q;
  assign underrun     = ur_q;

endmodule

// File: tb/tb_overlay_fetch.sv
`timescale 1ns/1ps
module tb_overlay_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // DUT A: default parameters (32-bit words, 2 pixels per word, depth 8)
  logic        rstA = 1'b1;
  logic        enA, ceA, deA, vsA;
  logic [15:0] pixA;
  logic        fsA, urA;
  overlay_fetch_if #(.ADDR_W(24), .WORD_W(32)) ifA ();
  overlay_fetch #(
    .ADDR_W(24), .WORD_W(32), .PIX_W(16), .FIFO_DEPTH(8), .BASE(24'd0)
  ) dutA (
    .clk(clk), .reset(rstA), .enable(enA), .ce_pix(ceA), .vsync(vsA), .de(deA),
    .mem(ifA), .pix_out(pixA), .frame_start(fsA), .underrun(urA)
  );

  // DUT B: 64-bit words, 4 pixels per word, depth 2
  logic        rstB = 1'b1;
  logic        enB, ceB, deB, vsB;
  logic [15:0] pixB;
  logic        fsB, urB;
  overlay_fetch_if #(.ADDR_W(24), .WORD_W(64)) ifB ();
  overlay_fetch #(
    .ADDR_W(24), .WORD_W(64), .PIX_W(16), .FIFO_DEPTH(2), .BASE(24'd0)
  ) dutB (
    .clk(clk), .reset(rstB), .enable(enB), .ce_pix(ceB), .vsync(vsB), .de(deB),
    .mem(ifB), .pix_out(pixB), .frame_start(fsB), .underrun(urB)
  );

  // Memory contents: a few fixed words plus a pattern elsewhere so every
  // expected pixel can be written down by hand.
  function automatic logic [31:0] memWordA(input logic [23:0] a);
    case (a)
      24'd0:   return 32'hBBBB_AAAA;
      24'd1:   return 32'hDDDD_CCCC;
      24'd5:   return 32'h1234_5678;
      default: return {16'hE000 + 16'(2 * a + 1), 16'hE000 + 16'(2 * a)};
    endcase
  endfunction

  function automatic logic [63:0] memWordB(input logic [23:0] a);
    return {16'hC000 + 16'(4 * a + 3), 16'hC000 + 16'(4 * a + 2),
            16'hC000 + 16'(4 * a + 1), 16'hC000 + 16'(4 * a)};
  endfunction

  // Memory responder A: ack three falling edges after a request is seen.
  logic        memOnA = 1'b1;
  int          waitA = 0;
  logic [23:0] pendAddrA;
  int          reqCntA = 0;
  int          fsCntA = 0;
  always @(negedge clk) begin
    ifA.mem_ack = 1'b0;
    if (waitA > 0) begin
      waitA--;
      if (waitA == 0) begin
        ifA.mem_ack = 1'b1;
        ifA.mem_din = memWordA(pendAddrA);
      end
    end
    if (ifA.mem_req === 1'b1) begin
      reqCntA++;
      if (memOnA) begin
        waitA     = 3;
        pendAddrA = ifA.mem_addr;
      end
    end
    if (fsA === 1'b1) fsCntA++;
  end

  // Memory responder B, same latency.
  int          waitB = 0;
  logic [23:0] pendAddrB;
  int          reqCntB = 0;
  always @(negedge clk) begin
    ifB.mem_ack = 1'b0;
    if (waitB > 0) begin
      waitB--;
      if (waitB == 0) begin
        ifB.mem_ack = 1'b1;
        ifB.mem_din = memWordB(pendAddrB);
      end
    end
    if (ifB.mem_req === 1'b1) begin
      reqCntB++;
      waitB     = 3;
      pendAddrB = ifB.mem_addr;
    end
  end

  typedef struct {
    logic        ce;
    logic        de;
    logic        vs;
    logic [15:0] expPix;
    logic        expUr;
    logic        expFs;
  } vecT;

  vecT vecs [12];

  function automatic vecT mkVec(input logic ce, input logic de, input logic vs,
                                input logic [15:0] pix, input logic ur, input logic fs);
    vecT v;
    v.ce = ce; v.de = de; v.vs = vs; v.expPix = pix; v.expUr = ur; v.expFs = fs;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vecT v);
    @(negedge clk);
    ceA = v.ce;
    deA = v.de;
    vsA = v.vs;
    @(posedge clk);
    #1;
  endtask

  task automatic consumeA();
    @(negedge clk); #1;
    ceA = 1'b1; deA = 1'b1;
    @(posedge clk); #1;
    ceA = 1'b0;
  endtask

  task automatic consumeB();
    @(negedge clk); #1;
    ceB = 1'b1; deB = 1'b1;
    @(posedge clk); #1;
    ceB = 1'b0;
  endtask

  task automatic resetA();
    @(negedge clk); #1;
    rstA = 1'b1;
    waitA = 0;
    reqCntA = 0;
    fsCntA = 0;
    repeat (2) @(negedge clk);
    #1;
    rstA = 1'b0;
  endtask

  // Returns at falling edge + 1 with found set once a request is visible
  // (optionally only at a given address), or after maxCycles.
  task automatic waitReqA(input int maxCycles, input bit anyAddr,
                          input logic [23:0] addr, output bit found);
    found = 1'b0;
    for (int i = 0; i < maxCycles && !found; i++) begin
      @(negedge clk); #1;
      if (ifA.mem_req === 1'b1 && (anyAddr || ifA.mem_addr == addr)) found = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit found;
    enA = 0; ceA = 0; deA = 0; vsA = 0;
    enB = 0; ceB = 0; deB = 0; vsB = 0;

    vecs[0]  = mkVec(1, 1, 0, 16'hAAAA, 0, 0);
    vecs[1]  = mkVec(0, 1, 0, 16'hAAAA, 0, 0);
    vecs[2]  = mkVec(1, 0, 0, 16'hAAAA, 0, 0);
    vecs[3]  = mkVec(1, 1, 0, 16'hBBBB, 0, 0);
    vecs[4]  = mkVec(1, 1, 0, 16'hCCCC, 0, 0);
    vecs[5]  = mkVec(1, 1, 0, 16'hDDDD, 0, 0);
    vecs[6]  = mkVec(1, 1, 0, 16'hE004, 0, 0);
    vecs[7]  = mkVec(1, 1, 0, 16'hE005, 0, 0);
    vecs[8]  = mkVec(1, 1, 1, 16'hE005, 0, 1);
    vecs[9]  = mkVec(0, 0, 1, 16'hE005, 0, 0);
    vecs[10] = mkVec(1, 1, 1, 16'h0000, 1, 0);
    vecs[11] = mkVec(0, 1, 1, 16'h0000, 1, 0);

    $display("[TB] reset state");
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset pix_out", pixA, 0);
    checkOutput("reset mem_req", ifA.mem_req, 0);
    checkOutput("reset mem_addr", ifA.mem_addr, 0);
    checkOutput("reset frame_start", fsA, 0);
    checkOutput("reset underrun", urA, 0);
    rstA = 1'b0;
    rstB = 1'b0;

    $display("[TB] prefetch fill");
    enA = 1'b1;
    waitReqA(10, 1'b1, 24'd0, found);
    checkOutput("first req seen", found, 1);
    checkOutput("first req addr", ifA.mem_addr, 0);
    repeat (80) @(negedge clk);
    #1;
    checkOutput("fill req count", reqCntA, 8);
    checkOutput("fill underrun", urA, 0);

    $display("[TB] vector table");
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d pix_out", i), pixA, vecs[i].expPix);
      checkOutput($sformatf("vec%0d underrun", i), urA, vecs[i].expUr);
      checkOutput($sformatf("vec%0d frame_start", i), fsA, vecs[i].expFs);
    end
    @(negedge clk);
    ceA = 0; deA = 0; vsA = 0;

    $display("[TB] memory never acks");
    memOnA = 1'b0;
    resetA();
    for (int i = 0; i < 3; i++) begin
      consumeA();
      checkOutput($sformatf("noack consume%0d pix_out", i), pixA, 0);
      checkOutput($sformatf("noack consume%0d underrun", i), urA, 1);
    end
    repeat (5) @(negedge clk);
    #1;
    checkOutput("noack underrun sticky", urA, 1);
    checkOutput("noack single request", reqCntA, 1);
    vsA = 1'b1;
    @(posedge clk); #1;
    checkOutput("noack vsync frame_start", fsA, 1);
    checkOutput("noack vsync clears underrun", urA, 0);
    @(posedge clk); #1;
    checkOutput("noack frame_start one cycle", fsA, 0);
    vsA = 1'b0;

    $display("[TB] vsync during read");
    memOnA = 1'b1;
    resetA();
    waitReqA(60, 1'b0, 24'd5, found);
    checkOutput("req at addr 5 seen", found, 1);
    vsA = 1'b1;
    waitReqA(20, 1'b1, 24'd0, found);
    checkOutput("restart req seen", found, 1);
    checkOutput("restart req addr", ifA.mem_addr, 0);
    vsA = 1'b0;
    repeat (60) @(negedge clk);
    #1;
    checkOutput("discard total reqs", reqCntA, 14);
    checkOutput("discard frame_start count", fsCntA, 1);
    consumeA();
    checkOutput("discard first pixel", pixA, 16'hAAAA);

    $display("[TB] disable with data buffered");
    @(negedge clk); #1;
    enA = 1'b0;
    @(posedge clk); #1;
    checkOutput("disable pix_out", pixA, 0);
    repeat (10) @(negedge clk);
    #1;
    checkOutput("disable no requests", reqCntA, 14);
    enA = 1'b1;
    consumeA();
    checkOutput("reenable fifo empty pix_out", pixA, 0);
    checkOutput("reenable fifo empty underrun", urA, 1);
    waitReqA(10, 1'b1, 24'd0, found);
    checkOutput("reenable req seen", found, 1);
    checkOutput("reenable continues addr", ifA.mem_addr, 8);
    repeat (10) @(negedge clk);
    consumeA();
    checkOutput("reenable first pixel", pixA, 16'hE010);

    $display("[TB] async reset during read");
    waitReqA(20, 1'b1, 24'd0, found);
    checkOutput("req before reset seen", found, 1);
    #1;
    rstA = 1'b1;
    #1;
    checkOutput("async reset mem_req", ifA.mem_req, 0);
    checkOutput("async reset mem_addr", ifA.mem_addr, 0);
    checkOutput("async reset pix_out", pixA, 0);
    enA = 1'b0;
    @(negedge clk); #1;
    rstA = 1'b0;

    $display("[TB] wide word, depth 2");
    enB = 1'b1;
    repeat (40) @(negedge clk);
    #1;
    checkOutput("B fill req count", reqCntB, 2);
    checkOutput("B fill underrun", urB, 0);
    for (int i = 0; i < 7; i++) begin
      consumeB();
      checkOutput($sformatf("B pixel%0d", i), pixB, 16'hC000 + 16'(i));
    end
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk); #1;
      if (ifB.mem_ack === 1'b1) found = 1'b1;
    end
    checkOutput("B ack seen", found, 1);
    ceB = 1'b1; deB = 1'b1;
    @(posedge clk); #1;
    ceB = 1'b0;
    checkOutput("B pixel7 with push", pixB, 16'hC007);
    repeat (20) @(negedge clk);
    #1;
    checkOutput("B req count after push/pop", reqCntB, 4);
    for (int i = 8; i < 16; i++) begin
      consumeB();
      checkOutput($sformatf("B pixel%0d", i), pixB, 16'hC000 + 16'(i));
    end
    checkOutput("B underrun clear", urB, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
